// File: rtl/hamming_secded_codec.sv
// Parametrised Hamming SECDED encoder/decoder behind a two-stage valid/ready
// pipeline. Stage 1 captures the input beat and its mode. Stage 2 holds the
// encoded codeword or the decoded result. Two saturating counters track how
// many decode beats carried single or double errors.
module hamming_secded_codec #(
  parameter  int DATA_W = 4,
  parameter  int CNT_W  = 16,
  localparam int R      = (DATA_W <= 4) ? 3 : (DATA_W <= 8) ? 4 : (DATA_W <= 16) ? 5 : 6,
  localparam int CODE_W = DATA_W + R + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EN,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_data,
  output logic [R-1:0]      out_syndrome,
  output logic              out_err_single,
  output logic              out_err_double,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  cnt_single,
  output logic [CNT_W-1:0]  cnt_double
);

  // Highest Hamming position; the overall parity bit sits one above it.
  localparam int               LAST_POS = CODE_W - 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Data bits go to the non-power-of-two positions, LSB first. Each parity bit
  // p(2^k) covers every position with bit k set. The top bit holds the overall
  // parity of everything below it.
  function automatic logic [CODE_W-1:0] secded_encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] cw;
    int j;
    cw = {CODE_W{1'b0}};
    j  = 0;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos-1] = d[j];
        j++;
      end
    end
    // Parity positions hold 0 at this point, and no parity position lies in
    // another parity bit's coverage, so each parity bit can be computed directly.
    for (int k = 0; k < R; k++) begin
      for (int pos = 1; pos < CODE_W; pos++) begin
        if (((pos >> k) & 1) != 0) begin
          cw[(1 << k) - 1] = cw[(1 << k) - 1] ^ cw[pos-1];
        end
      end
    end
    cw[CODE_W-1] = ^cw[CODE_W-2:0];
    return cw;
  endfunction

  // Syndrome: XOR of the position indices of all set bits below the overall parity.
  function automatic logic [R-1:0] secded_syndrome(input logic [CODE_W-1:0] cw);
    logic [R-1:0] s;
    s = {R{1'b0}};
    for (int pos = 1; pos < CODE_W; pos++) begin
      if (cw[pos-1]) begin
        s = s ^ R'(pos);
      end
    end
    return s;
  endfunction

  // Invert the bit at Hamming position s. A position of 0 leaves the word unchanged.
  function automatic logic [CODE_W-1:0] secded_flip(input logic [CODE_W-1:0] cw,
                                                    input logic [R-1:0]      s);
    logic [CODE_W-1:0] r;
    r = cw;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if (int'(s) == pos) begin
        r[pos-1] = ~r[pos-1];
      end
    end
    return r;
  endfunction

  // Read the data bits back out of the non-power-of-two positions.
  function automatic logic [DATA_W-1:0] secded_extract(input logic [CODE_W-1:0] cw);
    logic [DATA_W-1:0] d;
    int j;
    d = {DATA_W{1'b0}};
    j = 0;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[j] = cw[pos-1];
        j++;
      end
    end
    return d;
  endfunction

  logic              s1_valid_q, s1_valid_d;
  logic              s1_mode_q, s1_mode_d;
  logic [CODE_W-1:0] s1_data_q, s1_data_d;
  logic              out_valid_q, out_valid_d;
  logic [CODE_W-1:0] out_data_q, out_data_d;
  logic [R-1:0]      out_syn_q, out_syn_d;
  logic              out_single_q, out_single_d;
  logic              out_double_q, out_double_d;
  logic [CNT_W-1:0]  cnt_single_q, cnt_single_d;
  logic [CNT_W-1:0]  cnt_double_q, cnt_double_d;

  logic              advance_s;
  logic [R-1:0]      dec_syn_s;
  logic              dec_ov_s;
  logic [CODE_W-1:0] dec_fixed_s;
  logic [CODE_W-1:0] res_data_s;
  logic [R-1:0]      res_syn_s;
  logic              res_single_s;
  logic              res_double_s;

  // The whole pipeline moves together. It stalls only when the held output has not been taken.
  assign advance_s = EN & (~out_valid_q | out_ready);
  assign in_ready  = advance_s & ~rst;

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_syndrome   = out_syn_q;
  assign out_err_single = out_single_q;
  assign out_err_double = out_double_q;
  assign cnt_single     = cnt_single_q;
  assign cnt_double     = cnt_double_q;

  // Compute the encode or decode result for the beat currently in stage 1.
  always_comb begin
    dec_syn_s    = secded_syndrome(s1_data_q);
    dec_ov_s     = ^s1_data_q;
    dec_fixed_s  = s1_data_q;
    res_data_s   = {CODE_W{1'b0}};
    res_syn_s    = {R{1'b0}};
    res_single_s = 1'b0;
    res_double_s = 1'b0;
    if (s1_mode_q) begin
      if (dec_ov_s) begin
        // Odd overall parity: a single flip, unless the syndrome points past the word.
        if (int'(dec_syn_s) <= LAST_POS) begin
          res_single_s = 1'b1;
          dec_fixed_s  = secded_flip(s1_data_q, dec_syn_s);
        end else begin
          res_double_s = 1'b1;
        end
      end else begin
        if (dec_syn_s != {R{1'b0}}) begin
          res_double_s = 1'b1;
        end else begin
          res_double_s = 1'b0;
        end
      end
      res_data_s = {{(CODE_W-DATA_W){1'b0}}, secded_extract(dec_fixed_s)};
      res_syn_s  = dec_syn_s;
    end else begin
      res_data_s = secded_encode(s1_data_q[DATA_W-1:0]);
    end
  end

  // Next state of both pipeline stages: shift on advance, otherwise hold.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_mode_d    = s1_mode_q;
    s1_data_d    = s1_data_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_syn_d    = out_syn_q;
    out_single_d = out_single_q;
    out_double_d = out_double_q;
    if (advance_s) begin
      s1_valid_d  = in_valid;
      s1_mode_d   = mode;
      s1_data_d   = in_data;
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d   = res_data_s;
        out_syn_d    = res_syn_s;
        out_single_d = res_single_s;
        out_double_d = res_double_s;
      end else begin
        out_data_d   = out_data_q;
        out_syn_d    = out_syn_q;
        out_single_d = out_single_q;
        out_double_d = out_double_q;
      end
    end else begin
      s1_valid_d  = s1_valid_q;
      out_valid_d = out_valid_q;
    end
  end

  // Error counters: clear wins over an increment, and an increment stops at all-ones.
  always_comb begin
    cnt_single_d = cnt_single_q;
    cnt_double_d = cnt_double_q;
    if (EN && clr_cnt) begin
      cnt_single_d = {CNT_W{1'b0}};
      cnt_double_d = {CNT_W{1'b0}};
    end else begin
      if (advance_s && s1_valid_q && res_single_s && (cnt_single_q != CNT_MAX)) begin
        cnt_single_d = cnt_single_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_single_d = cnt_single_q;
      end
      if (advance_s && s1_valid_q && res_double_s && (cnt_double_q != CNT_MAX)) begin
        cnt_double_d = cnt_double_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_double_d = cnt_double_q;
      end
    end
  end

  // State registers. Synchronous reset discards any beats still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_mode_q    <= 1'b0;
      s1_data_q    <= {CODE_W{1'b0}};
      out_valid_q  <= 1'b0;
      out_data_q   <= {CODE_W{1'b0}};
      out_syn_q    <= {R{1'b0}};
      out_single_q <= 1'b0;
      out_double_q <= 1'b0;
      cnt_single_q <= {CNT_W{1'b0}};
      cnt_double_q <= {CNT_W{1'b0}};
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_mode_q    <= s1_mode_d;
      s1_data_q    <= s1_data_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_syn_q    <= out_syn_d;
      out_single_q <= out_single_d;
      out_double_q <= out_double_d;
      cnt_single_q <= cnt_single_d;
      cnt_double_q <= cnt_double_d;
    end
  end

endmodule

// File: tb/tb_hamming_secded_codec.sv
// Self-checking bench for hamming_secded_codec. Instance A uses DATA_W=4 and
// CNT_W=2. Instance B uses DATA_W=16 and CNT_W=16. A behavioural model predicts
// every output beat, and a set of hand-computed literal checks pins the model.
module tb_hamming_secded_codec;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  syn;
    logic        single;
    logic        dbl;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: DATA_W=4, CODE_W=8, R=3, CNT_W=2
  logic       a_en = 1'b1, a_mode = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b1, a_clr = 1'b0;
  logic       a_in_ready, a_out_valid, a_err_s, a_err_d;
  logic [7:0] a_in_data = 8'h00;
  logic [7:0] a_out_data;
  logic [2:0] a_syn;
  logic [1:0] a_cnt_s, a_cnt_d;

  // Instance B: DATA_W=16, CODE_W=22, R=5, CNT_W=16
  logic        b_en = 1'b1, b_mode = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b1, b_clr = 1'b0;
  logic        b_in_ready, b_out_valid, b_err_s, b_err_d;
  logic [21:0] b_in_data = 22'h0;
  logic [21:0] b_out_data;
  logic [4:0]  b_syn;
  logic [15:0] b_cnt_s, b_cnt_d;

  hamming_secded_codec #(.DATA_W(4), .CNT_W(2)) u_a (
    .clk(clk), .rst(rst), .EN(a_en), .mode(a_mode),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_syndrome(a_syn), .out_err_single(a_err_s), .out_err_double(a_err_d),
    .clr_cnt(a_clr), .cnt_single(a_cnt_s), .cnt_double(a_cnt_d));

  hamming_secded_codec #(.DATA_W(16), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .EN(b_en), .mode(b_mode),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_syndrome(b_syn), .out_err_single(b_err_s), .out_err_double(b_err_d),
    .clr_cnt(b_clr), .cnt_single(b_cnt_s), .cnt_double(b_cnt_d));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model built from the code's defining properties. When encoding,
  // the parity bits are chosen so that the XOR of the indices of all set
  // positions is zero, and the overall bit makes the popcount even. When
  // decoding, the syndrome and overall parity are classified by plain arithmetic.
  function automatic res_t model(input int dw, input logic m, input logic [63:0] x);
    res_t o;
    logic [63:0] d;
    int r, cw, j, s, ov;
    r = (dw == 4) ? 3 : (dw == 8) ? 4 : (dw == 16) ? 5 : 6;
    cw = dw + r + 1;
    o = '0;
    j = 0;
    s = 0;
    if (!m) begin
      for (int p = 1; p < cw; p++) begin
        if ((p & (p - 1)) != 0) begin
          o.data[p-1] = x[j];
          if (x[j]) s = s ^ p;
          j++;
        end
      end
      for (int k = 0; k < r; k++) begin
        if (((s >> k) & 1) != 0) o.data[(1 << k) - 1] = 1'b1;
      end
      o.data[cw-1] = ^o.data;
    end else begin
      for (int p = 1; p < cw; p++) begin
        if (x[p-1]) s = s ^ p;
      end
      ov = $countones(x) % 2;
      d = x;
      if (ov == 1 && s >= 1 && s <= cw - 1) d[s-1] = ~d[s-1];
      for (int p = 1; p < cw; p++) begin
        if ((p & (p - 1)) != 0) begin
          o.data[j] = d[p-1];
          j++;
        end
      end
      o.syn    = 8'(s);
      o.single = (ov == 1) && (s <= cw - 1);
      o.dbl    = ((ov == 1) && (s > cw - 1)) || ((ov == 0) && (s != 0));
    end
    return o;
  endfunction

  res_t qa[$], qb[$], obs_a[$], obs_b[$];
  int   obs_a_cyc[$];
  int   ecs_a = 0, ecd_a = 0, ecs_b = 0, ecd_b = 0;
  logic pv_a = 1'b0, pss_a = 1'b0, psd_a = 1'b0;
  logic [7:0] pd_a = 8'h00;
  logic [2:0] ps_a = 3'h0;

  // Monitor and compare for instance A. It samples on the falling edge.
  always @(negedge clk) begin
    res_t e, o;
    if (rst) begin
      qa.delete();
      ecs_a = 0; ecd_a = 0; pv_a = 1'b0;
    end else begin
      check("a_in_ready", 64'(a_in_ready), 64'(a_en && (!a_out_valid || a_out_ready)));
      if (pv_a) begin
        check("a_hold_valid", 64'(a_out_valid), 64'd1);
        check("a_hold_data", 64'(a_out_data), 64'(pd_a));
        check("a_hold_syn", 64'(a_syn), 64'(ps_a));
        check("a_hold_flags", 64'({a_err_s, a_err_d}), 64'({pss_a, psd_a}));
      end
      if (a_out_valid && a_out_ready && a_en) begin
        o = '0;
        o.data = 64'(a_out_data); o.syn = 8'(a_syn); o.single = a_err_s; o.dbl = a_err_d;
        obs_a.push_back(o);
        obs_a_cyc.push_back(cyc);
        check("a_beat_expected", 64'(qa.size() != 0), 64'd1);
        if (qa.size() != 0) begin
          e = qa.pop_front();
          check("a_data", o.data, e.data);
          check("a_syndrome", 64'(o.syn), 64'(e.syn));
          check("a_err_single", 64'(o.single), 64'(e.single));
          check("a_err_double", 64'(o.dbl), 64'(e.dbl));
        end
      end
      if (a_clr && a_en) begin
        ecs_a = 0; ecd_a = 0;
      end
      if (a_in_valid && a_in_ready) begin
        e = model(4, a_mode, 64'(a_in_data));
        qa.push_back(e);
        if (e.single && ecs_a < 3) ecs_a++;
        if (e.dbl && ecd_a < 3) ecd_a++;
      end
      pv_a  = a_out_valid && !(a_out_ready && a_en);
      pd_a  = a_out_data; ps_a = a_syn; pss_a = a_err_s; psd_a = a_err_d;
    end
  end

  // Monitor and compare for instance B.
  always @(negedge clk) begin
    res_t e, o;
    if (rst) begin
      qb.delete();
      ecs_b = 0; ecd_b = 0;
    end else begin
      check("b_in_ready", 64'(b_in_ready), 64'(b_en && (!b_out_valid || b_out_ready)));
      if (b_out_valid && b_out_ready && b_en) begin
        o = '0;
        o.data = 64'(b_out_data); o.syn = 8'(b_syn); o.single = b_err_s; o.dbl = b_err_d;
        obs_b.push_back(o);
        check("b_beat_expected", 64'(qb.size() != 0), 64'd1);
        if (qb.size() != 0) begin
          e = qb.pop_front();
          check("b_data", o.data, e.data);
          check("b_syndrome", 64'(o.syn), 64'(e.syn));
          check("b_err_single", 64'(o.single), 64'(e.single));
          check("b_err_double", 64'(o.dbl), 64'(e.dbl));
        end
      end
      if (b_clr && b_en) begin
        ecs_b = 0; ecd_b = 0;
      end
      if (b_in_valid && b_in_ready) begin
        e = model(16, b_mode, 64'(b_in_data));
        qb.push_back(e);
        if (e.single && ecs_b < 65535) ecs_b++;
        if (e.dbl && ecd_b < 65535) ecd_b++;
      end
    end
  end

  task automatic send_a(input logic m, input logic [7:0] d);
    int guard;
    guard = 0;
    a_mode = m; a_in_data = d; a_in_valid = 1'b1;
    @(negedge clk);
    while (!a_in_ready && guard < 100) begin @(negedge clk); guard++; end
    check("a_send_accepted", 64'(a_in_ready), 64'd1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic m, input logic [21:0] d);
    int guard;
    guard = 0;
    b_mode = m; b_in_data = d; b_in_valid = 1'b1;
    @(negedge clk);
    while (!b_in_ready && guard < 100) begin @(negedge clk); guard++; end
    check("b_send_accepted", 64'(b_in_ready), 64'd1);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic drain_a();
    int guard;
    guard = 0;
    while (qa.size() != 0 && guard < 200) begin @(posedge clk); #1; guard++; end
    repeat (2) begin @(posedge clk); #1; end
    check("a_drained", 64'(qa.size()), 64'd0);
  endtask

  task automatic drain_b();
    int guard;
    guard = 0;
    while (qb.size() != 0 && guard < 200) begin @(posedge clk); #1; guard++; end
    repeat (2) begin @(posedge clk); #1; end
    check("b_drained", 64'(qb.size()), 64'd0);
  endtask

  initial begin
    int base;
    res_t tmp;
    logic [7:0]  cw8;
    logic [15:0] w;
    logic [21:0] cw22;

    // Reset state, including in_ready low during reset and high right after it.
    @(negedge clk);
    check("rst_in_ready_a", 64'(a_in_ready), 64'd0);
    check("rst_in_ready_b", 64'(b_in_ready), 64'd0);
    @(posedge clk); #1;
    check("rst_out_valid_a", 64'(a_out_valid), 64'd0);
    check("rst_out_data_a", 64'(a_out_data), 64'd0);
    check("rst_cnt_a", 64'({a_cnt_s, a_cnt_d}), 64'd0);
    check("rst_out_valid_b", 64'(b_out_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready_a", 64'(a_in_ready), 64'd1);
    @(posedge clk); #1;

    // Encode 4'hB: the result appears two cycles after acceptance.
    send_a(1'b0, 8'h0B);
    @(negedge clk);
    check("enc_latency_not_early", 64'(a_out_valid), 64'd0);
    @(negedge clk);
    check("enc_latency_valid", 64'(a_out_valid), 64'd1);
    check("enc_B_codeword", 64'(a_out_data), 64'h55);
    check("enc_B_syn_flags", 64'({a_syn, a_err_s, a_err_d}), 64'd0);
    @(posedge clk); #1;
    drain_a();

    // Decode 55 / 45 / D5 back to back.
    base = obs_a.size();
    send_a(1'b1, 8'h55); send_a(1'b1, 8'h45); send_a(1'b1, 8'hD5);
    drain_a();
    check("dec3_count", 64'(obs_a.size() - base), 64'd3);
    if (obs_a.size() - base == 3) begin
      check("dec55_data", obs_a[base].data, 64'hB);
      check("dec55_flags", 64'({obs_a[base].single, obs_a[base].dbl}), 64'd0);
      check("dec45_syn", 64'(obs_a[base+1].syn), 64'd5);
      check("dec45_data_single", {obs_a[base+1].data[59:0], obs_a[base+1].single, obs_a[base+1].dbl, 2'b00}, {60'hB, 1'b1, 1'b0, 2'b00});
      check("decD5_syn", 64'(obs_a[base+2].syn), 64'd0);
      check("decD5_data_single", {obs_a[base+2].data[59:0], obs_a[base+2].single, 3'b000}, {60'hB, 1'b1, 3'b000});
      check("dec_consecutive_1", 64'(obs_a_cyc[base+1] - obs_a_cyc[base]), 64'd1);
      check("dec_consecutive_2", 64'(obs_a_cyc[base+2] - obs_a_cyc[base+1]), 64'd1);
    end
    check("cnt_single_2", 64'(a_cnt_s), 64'd2);

    // Double error.
    base = obs_a.size();
    send_a(1'b1, 8'h56);
    drain_a();
    check("dec56_count", 64'(obs_a.size() - base), 64'd1);
    if (obs_a.size() - base == 1) begin
      check("dec56_syn", 64'(obs_a[base].syn), 64'd3);
      check("dec56_flags", 64'({obs_a[base].single, obs_a[base].dbl}), 64'b01);
    end
    check("cnt_double_1", 64'(a_cnt_d), 64'd1);

    // clr_cnt has no effect while EN is low, and in_ready is low then.
    a_en = 1'b0; a_clr = 1'b1;
    @(negedge clk);
    check("en_low_in_ready", 64'(a_in_ready), 64'd0);
    @(posedge clk); #1;
    a_clr = 1'b0; a_en = 1'b1;
    @(negedge clk);
    check("en_low_clr_ignored", 64'({a_cnt_s, a_cnt_d}), 64'({2'd2, 2'd1}));
    @(posedge clk); #1;

    // Stall: three beats go in with out_ready low for four cycles.
    base = obs_a.size();
    a_out_ready = 1'b0;
    fork
      begin send_a(1'b0, 8'h01); send_a(1'b0, 8'h02); send_a(1'b0, 8'h03); end
      begin
        repeat (4) @(negedge clk);
        check("stall_in_ready_low", 64'(a_in_ready), 64'd0);
        check("stall_out_valid_held", 64'(a_out_valid), 64'd1);
        @(posedge clk); #1;
        a_out_ready = 1'b1;
      end
    join
    drain_a();
    check("stall_count", 64'(obs_a.size() - base), 64'd3);
    if (obs_a.size() - base == 3) begin
      check("stall_order", {40'd0, obs_a[base].data[7:0], obs_a[base+1].data[7:0], obs_a[base+2].data[7:0]}, 64'h87991E);
    end

    // Saturation at CNT_W=2, then clr_cnt in the cycle the next error beat loads.
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    repeat (5) send_a(1'b1, 8'h45);
    drain_a();
    check("cnt_sat_3", 64'(a_cnt_s), 64'd3);
    send_a(1'b1, 8'h45);
    a_clr = 1'b1;
    @(posedge clk); #1;
    a_clr = 1'b0;
    @(negedge clk);
    check("clr_beats_inc", 64'(a_cnt_s), 64'd0);
    @(posedge clk); #1;
    drain_a();

    // Randomized traffic on A with random EN / out_ready / mode.
    for (int i = 0; i < 600; i++) begin
      a_en        = ($urandom_range(0, 9) != 0);
      a_out_ready = ($urandom_range(0, 3) != 0);
      a_in_valid  = 1'($urandom_range(0, 1));
      a_mode      = 1'($urandom_range(0, 1));
      if (a_mode && $urandom_range(0, 4) != 0) begin
        tmp = model(4, 1'b0, 64'($urandom));
        cw8 = tmp.data[7:0];
        for (int f = 0; f < int'($urandom_range(0, 2)); f++) cw8[$urandom_range(0, 7)] ^= 1'b1;
        a_in_data = cw8;
      end else begin
        a_in_data = 8'($urandom);
      end
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0; a_en = 1'b1; a_out_ready = 1'b1;
    drain_a();
    check("a_rand_cnt_single", 64'(a_cnt_s), 64'(ecs_a));
    check("a_rand_cnt_double", 64'(a_cnt_d), 64'(ecd_a));

    // DATA_W=16: encode a random word, then decode every single-bit flip.
    w = 16'($urandom);
    send_b(1'b0, {6'h3F, w});
    drain_b();
    tmp  = model(16, 1'b0, 64'(w));
    cw22 = tmp.data[21:0];
    base = obs_b.size();
    for (int i = 0; i < 22; i++) send_b(1'b1, cw22 ^ (22'd1 << i));
    drain_b();
    check("b_flip_count", 64'(obs_b.size() - base), 64'd22);
    for (int i = 0; i < 22 && base + i < obs_b.size(); i++) begin
      check("b_flip_data_single", {obs_b[base+i].data[61:0], obs_b[base+i].single, obs_b[base+i].dbl}, {46'd0, w, 1'b1, 1'b0});
    end
    check("b_cnt_single_22", 64'(b_cnt_s), 64'd22);

    // Randomized decode / encode on B.
    for (int i = 0; i < 150; i++) begin
      send_b(1'($urandom_range(0, 1)), 22'($urandom));
    end
    drain_b();
    check("b_rand_cnt_single", 64'(b_cnt_s), 64'(ecs_b));
    check("b_rand_cnt_double", 64'(b_cnt_d), 64'(ecd_b));

    // Reset asserted mid-stream.
    fork
      begin for (int i = 0; i < 6; i++) send_b(1'b1, cw22 ^ (22'd1 << i)); end
      begin
        repeat (4) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(b_out_valid), 64'd0);
        check("midrst_counters", 64'({b_cnt_s, b_cnt_d}), 64'd0);
      end
    join
    drain_b();
    check("b_post_rst_cnt", 64'(b_cnt_s), 64'(ecs_b));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/hamming_secded_codec.md
Name: hamming_secded_codec

Overview:
Parametrised Hamming SECDED (single-error-correct, double-error-detect) encoder/decoder. It generalises the existing 4-bit Hamming(7,4) encoder to DATA_W data bits, adds an overall-parity bit, a per-beat encode/decode mode, a 2-stage valid/ready pipeline and saturating error counters. It sits between the data source/sink and the channel model in the Hamming system.

Parameters:
DATA_W, 4, data width; legal values 4, 8, 16, 32.
R, derived (3/4/5/6 for DATA_W 4/8/16/32), Hamming parity-bit count; not user-overridable.
CODE_W, derived = DATA_W+R+1, SECDED codeword width.
CNT_W, 16, width of each error counter.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
EN  in  1  global enable; low freezes the pipeline, counters and handshakes.
mode  in  1  0 = encode, 1 = decode; sampled with each input beat.
in_valid  in  1  input beat valid.
in_ready  out  1  block accepts a beat this cycle.
in_data  in  CODE_W  encode: data in [DATA_W-1:0], upper bits ignored; decode: received codeword.
out_valid  out  1  output beat valid.
out_ready  in  1  sink accepts the output beat.
out_data  out  CODE_W  encode: codeword; decode: corrected data in [DATA_W-1:0], upper bits 0.
out_syndrome  out  R  decode: Hamming syndrome; encode: 0.
out_err_single  out  1  decode: single error detected and corrected.
out_err_double  out  1  decode: uncorrectable error detected.
clr_cnt  in  1  synchronous clear of both counters.
cnt_single  out  CNT_W  saturating count of single-error beats.
cnt_double  out  CNT_W  saturating count of double-error beats.

Behaviour:
- Codeword layout: bit i-1 holds Hamming position i for i = 1..CODE_W-1.
- Parity bit p(2^k) sits at position 2^k and equals the XOR of all positions with bit k set.
- Data bits fill the remaining positions in ascending order, LSB first.
- Bit CODE_W-1 holds the overall parity, the XOR of bits [CODE_W-2:0].
- For DATA_W=4, bits [6:0] = {d3,d2,d1,p4,d0,p2,p1}, identical to the existing encoder.
- Decode: s = XOR of the position indices of all set bits in [CODE_W-2:0]; ov = XOR of all CODE_W bits.
  - s=0, ov=0: no error; flags 0.
  - ov=1, s=0: overall-parity bit flipped; err_single=1; data unchanged.
  - ov=1, 1<=s<=CODE_W-1: flip position s, extract data; err_single=1.
  - ov=1, s>CODE_W-1: err_double=1; data extracted uncorrected.
  - ov=0, s!=0: err_double=1; data extracted uncorrected.
  - err_single and err_double are never both 1.
- Pipeline: stage 1 registers the input beat and mode; stage 2 computes the result and registers all out_* signals.
- advance = EN && (!out_valid || out_ready); in_ready = advance.
- Input handshake: beat accepted when in_valid && in_ready.
- Output handshake: beat consumed when out_valid && out_ready.
- Latency: out_valid asserts exactly 2 cycles after acceptance when not stalled. Throughput is 1 beat/cycle, with no bubbles under continuous valid/ready.
- Stall: while advance=0, both stages and all out_* hold their values. No beat is lost or duplicated, and order is preserved.
- Mode may change on every beat; each result uses the mode of its own beat.
- Counters: increment when a decode beat with the matching flag loads into stage 2. Saturate at all-ones, no wrap.
- clr_cnt has priority over a simultaneous increment (result 0). clr_cnt is ignored while EN=0.
- Reset (including mid-stream): clears both stage valids, out_data, out_syndrome, both flags and both counters to 0.
  - In-flight beats are discarded.
  - in_ready=0 during the reset cycle and equals EN from the following cycle.
- EN=0: in_ready=0; outputs hold.

Test Plan:
1. DATA_W=4, encode in_data=4'hB -> out_data=8'h55 two cycles later; syndrome 0, flags 0.
2. Decode 8'h55, 8'h45, 8'hD5 back-to-back ->
   - 8'h55: data 4'hB, no flags.
   - 8'h45: syndrome 5, err_single, data 4'hB.
   - 8'hD5: syndrome 0, err_single, data 4'hB.
   - Results arrive on consecutive cycles; cnt_single=2.
3. Decode 8'h56 -> syndrome 3, err_double=1, err_single=0, cnt_double=1.
4. Stream 3 beats with out_ready=0 for 4 cycles -> in_ready drops once both stages are full. After out_ready=1, all beats emerge in order with no loss.
5. CNT_W=2, 5 single-error beats -> cnt_single=3. Assert clr_cnt together with a 6th error beat -> cnt_single=0.
6. DATA_W=16, encode a random word, flip each single bit in turn, then decode -> original data and err_single for every bit. Reset asserted mid-stream -> out_valid=0 and counters=0 next cycle.
